// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - time-multiplexed 4-digit seven-segment display driver
module seg7_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic          load_pending;

    logic          cnt_last;
    logic          frame_end;
    logic          lit;
    logic [3:0]    nibble;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot bookkeeping and selection of the digit currently being scanned.
    always_comb begin
        cnt_last  = (cnt == CNT_LAST);
        frame_end = cnt_last && (idx == 2'd3);
        lit       = (cnt >= GUARD_C) && !blank_mask[idx];
        case (idx)
            2'd0:    nibble = shadow[3:0];
            2'd1:    nibble = shadow[7:4];
            2'd2:    nibble = shadow[11:8];
            default: nibble = shadow[15:12];
        endcase
    end

    // Prescaler, frame-aligned capture of the display word, registered drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 2'd0;
            shadow       <= 16'h0000;
            load_pending <= 1'b1;
            an           <= 4'hF;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // The word is only taken at frame edges so a frame never mixes two values.
            if (load_pending || frame_end) begin
                shadow <= value;
            end
            load_pending <= 1'b0;
            frame_tick   <= frame_end;

            // Guard interval keeps all anodes off while segments settle.
            if (lit) begin
                an  <= ~(4'b0001 << idx);
                seg <= decode(nibble);
                dp  <= ~dp_mask[idx];
            end else begin
                an  <= 4'hF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - self-checking bench for seg7_scanner
module tb_seg7_scanner;

    localparam int RD = 4;
    localparam int GD = 1;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg7_scanner #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .value(value), .blank_mask(blank_mask),
        .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;               // rising edges since reset release
    logic [15:0] sh_m = 16'h0000;
    logic [6:0]  dec_tab [16];

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } vec_t;

    vec_t scan_tab [13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, n, got, exp);
        end
    endtask

    // Expected {an,seg,dp,frame_tick} after edge k, from slot arithmetic.
    function automatic logic [12:0] model_out(input int k);
        int p, i, c;
        logic tk;
        p  = (k - 1) % FRAME;
        i  = p / RD;
        c  = p % RD;
        tk = (k % FRAME) == 0;
        if (c < GD || blank_mask[i])
            return {4'hF, 7'h7F, 1'b1, tk};
        return {~(4'b0001 << i), dec_tab[sh_m[4*i +: 4]], ~dp_mask[i], tk};
    endfunction

    task automatic step();
        logic [12:0] e;
        e = model_out(n + 1);
        if ((n + 1) == 1 || ((n + 1) % FRAME) == 0) sh_m = value;
        @(posedge clk); #1;
        n++;
        chk("model", {19'd0, an, seg, dp, frame_tick}, {19'd0, e});
        tests++;
        if ((an != 4'hF && $countones(~an) != 1) || (an == 4'hF && seg != 7'h7F)) begin
            fails++;
            $display("FAIL invariant at cycle %0d: an=%b seg=%b", n, an, seg);
        end
    endtask

    task automatic do_reset(input int cycles, input logic [15:0] v);
        rst = 1'b1;
        value = v;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("reset_out", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst = 1'b0;
        n = 0;
        sh_m = 16'h0000;
    endtask

    initial begin
        dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        scan_tab[0]  = '{2,  4'b1110, 7'b0001110, 1'b1, 1'b0};
        scan_tab[1]  = '{4,  4'b1110, 7'b0001110, 1'b1, 1'b0};
        scan_tab[2]  = '{5,  4'b1111, 7'b1111111, 1'b1, 1'b0};
        scan_tab[3]  = '{6,  4'b1101, 7'b0001000, 1'b1, 1'b0};
        scan_tab[4]  = '{8,  4'b1101, 7'b0001000, 1'b1, 1'b0};
        scan_tab[5]  = '{9,  4'b1111, 7'b1111111, 1'b1, 1'b0};
        scan_tab[6]  = '{10, 4'b1011, 7'b0100100, 1'b1, 1'b0};
        scan_tab[7]  = '{12, 4'b1011, 7'b0100100, 1'b1, 1'b0};
        scan_tab[8]  = '{14, 4'b0111, 7'b1111001, 1'b1, 1'b0};
        scan_tab[9]  = '{16, 4'b0111, 7'b1111001, 1'b1, 1'b1};
        scan_tab[10] = '{17, 4'b1111, 7'b1111111, 1'b1, 1'b0};
        scan_tab[11] = '{32, 4'b0111, 7'b1111001, 1'b1, 1'b1};
        scan_tab[12] = '{48, 4'b0111, 7'b1111001, 1'b1, 1'b1};

        // Reset with all-ones word, then the initial capture on cycle 1.
        do_reset(3, 16'hFFFF);
        step();
        chk("reset_c1", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        chk("init_capture", {16'd0, dut.shadow}, {16'd0, 16'hFFFF});

        // Scan with table of expected checkpoints.
        do_reset(1, 16'h12AF);
        for (int t = 0; t < 13; t++) begin
            while (n < scan_tab[t].cyc) step();
            chk($sformatf("scan_c%0d", scan_tab[t].cyc), {19'd0, an, seg, dp, frame_tick},
                {19'd0, scan_tab[t].an, scan_tab[t].seg, scan_tab[t].dp, scan_tab[t].tick});
        end

        // Tearing: word changes mid-frame, display holds until the frame edge.
        do_reset(1, 16'h12AF);
        while (n < 6) step();
        value = 16'h3400;
        while (n < 30) begin
            step();
            if (n == 12) chk("tear_d2", {25'd0, seg}, {25'd0, 7'b0100100});
            if (n == 16) chk("tear_d3", {25'd0, seg}, {25'd0, 7'b1111001});
            if (n == 18) chk("new_d0", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b1000000});
            if (n == 30) chk("new_d3", {21'd0, an, seg}, {21'd0, 4'b0111, 7'b0110000});
        end

        // Blanking of the upper two digits.
        do_reset(1, 16'h12AF);
        blank_mask = 4'b1100;
        while (n < 48) begin
            step();
            chk("blank_an", {30'd0, an[3:2]}, {30'd0, 2'b11});
            if (n == 6) chk("blank_d1", {28'd0, an}, {28'd0, 4'b1101});
        end
        blank_mask = 4'h0;

        // Decimal point on digit 0 only.
        do_reset(1, 16'h12AF);
        dp_mask = 4'b0001;
        while (n < 32) begin
            step();
            chk("dp_rel", {31'd0, dp}, {31'd0, !(an == 4'b1110)});
        end
        dp_mask = 4'h0;

        // Mid-frame reset while digit 2 is lit.
        begin
            int budget = 0;
            while (an != 4'b1011 && budget < 64) begin
                step();
                budget++;
            end
            chk("find_d2", {28'd0, an}, {28'd0, 4'b1011});
        end
        value = 16'h5A5A;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset", {21'd0, an, seg}, {21'd0, 4'hF, 7'h7F});
        rst = 1'b0;
        n = 0;
        sh_m = 16'h0000;
        while (n < 4) begin
            step();
            if (n == 2) chk("post_reset_d0", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0001000});
        end

        // Randomised inputs against the model.
        do_reset(2, 16'($urandom));
        for (int r = 0; r < 400; r++) begin
            value      = 16'($urandom);
            blank_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            if ($urandom_range(0, 3) == 0) blank_mask = 4'h0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scanner.md
Name: seg7_scanner

Overview:
- Time-multiplexed 4-digit seven-segment display driver, directly downstream of the processor core.
- Consumes the core's 16-bit `result` debug word and shows it as four hex digits on the board display.
- Captures the input once per full scan frame, so a digit update never tears mid-frame. Adds an anode guard interval against ghosting.
- Emits a one-cycle `frame_tick` pulse per frame for bench/trace synchronisation.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is selected; legal range >= 2.
- GUARD, 16, cycles at start of each digit slot with all anodes off; legal range 1 .. REFRESH_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- value  input  16  word to display; digit i = value[4i+3:4i], digit 0 rightmost
- blank_mask  input  4  bit i = 1 keeps digit i dark
- dp_mask  input  4  bit i = 1 lights decimal point of digit i
- an  output  4  anode enables, active-low, an[i] drives digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse at frame boundary

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: cnt=0, idx=0, shadow=0, load_pending=1, an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
- Reset mid-operation: the next edge forces all of the above, regardless of cnt/idx.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1 mod 4.
  - Otherwise: cnt<=cnt+1.
- Frame boundary (cnt==REFRESH_DIV-1 && idx==3):
  - shadow<=value and frame_tick<=1 on that edge.
  - frame_tick is 0 on every other edge.
- Initial capture: in the first cycle with rst=0 and load_pending=1, shadow<=value and load_pending<=0. No frame_tick for this capture.
- Shadow updates only at these two events. `value` changes between them are ignored.
- Outputs are registered, computed from the pre-edge cnt/idx/shadow (1-cycle latency):
  - Dark case, if cnt<GUARD or blank_mask[idx]==1: an=4'hF, seg=7'h7F, dp=1.
  - Lit case, otherwise:
    - an = all ones except bit idx = 0.
    - seg = decode(shadow nibble idx).
    - dp = ~dp_mask[idx].
  - blank_mask and dp_mask are sampled live each cycle, not shadowed.
- Decode table (active-low {g..a}):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Digit timing: per digit slot, GUARD dark cycles then REFRESH_DIV-GUARD lit cycles. Frame length = 4*REFRESH_DIV cycles.
- Invariants:
  - At most one anode low in any cycle.
  - seg==7'h7F whenever an==4'hF.
  - blank_mask does not alter cnt/idx sequencing.
- Counter width: ceil(log2(REFRESH_DIV)) bits, wrap only via the terminal compare, never by overflow.

Test Plan:
(All with REFRESH_DIV=4, GUARD=1; cycle n = nth rising edge after rst falls.)
- Reset: rst high 3 cycles with value=16'hFFFF.
  - -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0 throughout and at cycle 1.
  - -> shadow=16'hFFFF after cycle 1.
- Scan: value=16'h12AF, masks 0.
  - -> cycles 2-4: an=1110, seg=0001110.
  - -> cycle 5: an=1111.
  - -> cycles 6-8: an=1101, seg=0001000.
  - -> cycles 10-12: an=1011, seg=0100100.
  - -> cycles 14-16: an=0111, seg=1111001.
  - -> frame_tick=1 only at cycles 16, 32, 48.
- Tearing: change value 12AF->3400 at cycle 7.
  - -> digits 2/3 in cycles 10-16 still show 2, 1.
  - -> from cycle 18, digit 0 shows 0 (1000000) and digit 3 shows 3 (0110000).
- Blanking: blank_mask=4'b1100, value=16'h12AF.
  - -> an[3], an[2] never 0; digits 0/1 lit at the same cycles as the scan test.
  - -> frame_tick period still 16.
- Decimal point: dp_mask=4'b0001.
  - -> dp=0 exactly when an=1110, dp=1 in all other cycles.
- Mid-frame reset: assert rst 1 cycle while an=1011.
  - -> next cycle an=4'hF, seg=7'h7F.
  - -> after release, digit 0 is lit first (cycles 2-4) with the newly captured value.
